// File: rtl/base58_char_serializer.sv
// base58_char_serializer
// Takes one 3-character base-58 ASCII frame (char_2 most significant) and
// emits it byte by byte over a valid/ready stream, most significant first.
// Counts fully emitted frames in frame_count (wraps modulo 2^CNT_W).
//
// Optional feature macro: LEADING_ZERO_SUPPRESS_EN
//   defined   : leading '0' (8'h30) characters in char_2/char_1 are skipped
//               at capture; char_0 is always emitted.
//   undefined : every frame is exactly 3 bytes, no comparison logic.
module base58_char_serializer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       char_2,
  input  logic [7:0]       char_1,
  input  logic [7:0]       char_0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index encoding: 0 selects char_2, 1 selects char_1, 2 selects char_0.
  localparam logic [1:0] IDX_C2 = 2'd0;
  localparam logic [1:0] IDX_C1 = 2'd1;
  localparam logic [1:0] IDX_C0 = 2'd2;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       c2_q, c2_d;
  logic [7:0]       c1_q, c1_d;
  logic [7:0]       c0_q, c0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             xfer;
  logic             at_last;
  logic [1:0]       start_idx;

  // Handshake qualifiers shared by the next-state logic.
  always_comb begin
    accept  = (state_q == IDLE) && in_valid;
    xfer    = (state_q == SEND) && out_ready;
    at_last = (idx_q == IDX_C0);
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  // First byte to emit: skip leading '0' characters, never past char_0.
  always_comb begin
    start_idx = IDX_C2;
    if (char_2 == 8'h30) begin
      if (char_1 == 8'h30) begin
        start_idx = IDX_C0;
      end else begin
        start_idx = IDX_C1;
      end
    end
  end
`else
  // First byte to emit: always char_2.
  always_comb begin
    start_idx = IDX_C2;
  end
`endif

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c2_q    <= '0;
      c1_q    <= '0;
      c0_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c2_q    <= c2_d;
      c1_q    <= c1_d;
      c0_q    <= c0_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: capture in IDLE, advance index on each transfer, close frame on last.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c2_d    = c2_q;
    c1_d    = c1_q;
    c0_d    = c0_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          c2_d    = char_2;
          c1_d    = char_1;
          c0_d    = char_0;
          idx_d   = start_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (at_last) begin
            idx_d   = '0;
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs: handshake flags from state, byte selected by the held index.
  always_comb begin
    in_ready    = (state_q == IDLE) && !rst;
    out_valid   = (state_q == SEND);
    out_last    = 1'b0;
    out_data    = '0;
    frame_count = cnt_q;
    if (state_q == SEND) begin
      out_last = at_last;
      unique case (idx_q)
        IDX_C2:  out_data = c2_q;
        IDX_C1:  out_data = c1_q;
        IDX_C0:  out_data = c0_q;
        default: out_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_base58_char_serializer.sv
// Directed testbench for base58_char_serializer. Two instances share stimulus:
// dut (default CNT_W) and dut2 (CNT_W=2) for counter wrap checks.
module tb_base58_char_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  char_2, char_1, char_0;
  logic        out_ready;

  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_data;
  logic [15:0] frame_count;

  logic        in_ready2, out_valid2, out_last2;
  logic [7:0]  out_data2;
  logic [1:0]  frame_count2;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] exp_fc;

  base58_char_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .char_2(char_2), .char_1(char_1), .char_0(char_0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_count(frame_count)
  );

  base58_char_serializer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .char_2(char_2), .char_1(char_1), .char_0(char_0),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_last(out_last2), .frame_count(frame_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then settle past the edge before observing/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    char_2 = 8'h00; char_1 = 8'h00; char_0 = 8'h00;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h want=00", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_frame_count got=%0d want=0", frame_count); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b want=1", in_ready); end
    exp_fc = 16'd0;
  endtask

  task automatic test_basic();
    char_2 = 8'h30; char_1 = 8'h33; char_0 = 8'h51;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h30 || out_last !== 1'b0)
      begin bad++; $display("FAIL basic_b0 got v=%b d=%h l=%b want v=1 d=30 l=0", out_valid, out_data, out_last); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy_in_ready got=%b want=0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_last !== 1'b0)
      begin bad++; $display("FAIL basic_b1 got v=%b d=%h l=%b want v=1 d=33 l=0", out_valid, out_data, out_last); end
    total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL basic_fc_mid got=%0d want=%0d", frame_count, exp_fc); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h51 || out_last !== 1'b1)
      begin bad++; $display("FAIL basic_b2 got v=%b d=%h l=%b want v=1 d=51 l=1", out_valid, out_data, out_last); end
    tick();
    exp_fc = exp_fc + 16'd1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL basic_idle got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL basic_fc got=%0d want=%0d", frame_count, exp_fc); end
  endtask

  task automatic test_backpressure();
    char_2 = 8'h30; char_1 = 8'h33; char_0 = 8'h51;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 8'h30) begin bad++; $display("FAIL bp_b0 got=%h want=30", out_data); end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_last !== 1'b0)
        begin bad++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=33 l=0", i, out_valid, out_data, out_last); end
      tick();
    end
    total++; if (out_data !== 8'h33) begin bad++; $display("FAIL bp_hold_end got=%h want=33", out_data); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h51 || out_last !== 1'b1)
      begin bad++; $display("FAIL bp_b2 got v=%b d=%h l=%b want v=1 d=51 l=1", out_valid, out_data, out_last); end
    tick();
    exp_fc = exp_fc + 16'd1;
    total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL bp_fc got=%0d want=%0d", frame_count, exp_fc); end
  endtask

  task automatic test_reset_mid_frame();
    char_2 = 8'h41; char_1 = 8'h42; char_0 = 8'h43;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_data !== 8'h42) begin bad++; $display("FAIL rmid_b1 got=%h want=42", out_data); end
    // Reset with simultaneous in_valid: reset must win.
    rst = 1'b1; in_valid = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready_rst got=%b want=0", in_ready); end
    exp_fc = 16'd0;
    total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL rmid_fc got=%0d want=%0d", frame_count, exp_fc); end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || frame_count !== exp_fc)
      begin bad++; $display("FAIL rmid_no_resume got v=%b fc=%0d want v=0 fc=%0d", out_valid, frame_count, exp_fc); end
  endtask

  task automatic test_ignore_inputs();
    char_2 = 8'h61; char_1 = 8'h62; char_0 = 8'h63;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    char_2 = 8'hFF; char_1 = 8'hEE; char_0 = 8'hDD;
    total++; if (out_data !== 8'h61) begin bad++; $display("FAIL ign_b0 got=%h want=61", out_data); end
    tick();
    char_1 = 8'h11;
    total++; if (out_data !== 8'h62) begin bad++; $display("FAIL ign_b1 got=%h want=62", out_data); end
    tick();
    char_0 = 8'h22;
    total++; if (out_data !== 8'h63 || out_last !== 1'b1)
      begin bad++; $display("FAIL ign_b2 got d=%h l=%b want d=63 l=1", out_data, out_last); end
    in_valid = 1'b0;
    tick();
    exp_fc = exp_fc + 16'd1;
    total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL ign_fc got=%0d want=%0d", frame_count, exp_fc); end
  endtask

  task automatic test_suppress();
    char_2 = 8'h30; char_1 = 8'h30; char_0 = 8'h35;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
    total++; if (out_valid !== 1'b1 || out_data !== 8'h35 || out_last !== 1'b1)
      begin bad++; $display("FAIL sup5_b0 got v=%b d=%h l=%b want v=1 d=35 l=1", out_valid, out_data, out_last); end
`else
    total++; if (out_data !== 8'h30 || out_last !== 1'b0)
      begin bad++; $display("FAIL nosup5_b0 got d=%h l=%b want d=30 l=0", out_data, out_last); end
    tick();
    total++; if (out_data !== 8'h30 || out_last !== 1'b0)
      begin bad++; $display("FAIL nosup5_b1 got d=%h l=%b want d=30 l=0", out_data, out_last); end
    tick();
    total++; if (out_data !== 8'h35 || out_last !== 1'b1)
      begin bad++; $display("FAIL nosup5_b2 got d=%h l=%b want d=35 l=1", out_data, out_last); end
`endif
    tick();
    exp_fc = exp_fc + 16'd1;
    total++; if (out_valid !== 1'b0 || frame_count !== exp_fc)
      begin bad++; $display("FAIL sup5_end got v=%b fc=%0d want v=0 fc=%0d", out_valid, frame_count, exp_fc); end

    char_2 = 8'h30; char_1 = 8'h34; char_0 = 8'h4E;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifndef LEADING_ZERO_SUPPRESS_EN
    total++; if (out_data !== 8'h30 || out_last !== 1'b0)
      begin bad++; $display("FAIL nosup255_b0 got d=%h l=%b want d=30 l=0", out_data, out_last); end
    tick();
`endif
    total++; if (out_valid !== 1'b1 || out_data !== 8'h34 || out_last !== 1'b0)
      begin bad++; $display("FAIL sup255_b1 got v=%b d=%h l=%b want v=1 d=34 l=0", out_valid, out_data, out_last); end
    tick();
    total++; if (out_data !== 8'h4E || out_last !== 1'b1)
      begin bad++; $display("FAIL sup255_b2 got d=%h l=%b want d=4e l=1", out_data, out_last); end
    tick();
    exp_fc = exp_fc + 16'd1;
    total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL sup255_fc got=%0d want=%0d", frame_count, exp_fc); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_fc2;
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_fc  = 16'd0;
    exp_fc2 = 2'd0;
    char_2 = 8'h31; char_1 = 8'h32; char_0 = 8'h33;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      tick();
      total++; if (out_valid2 !== 1'b1 || out_data2 !== 8'h31 || in_ready2 !== 1'b0)
        begin bad++; $display("FAIL b2b_f%0d_b0 got v=%b d=%h r=%b want v=1 d=31 r=0", f, out_valid2, out_data2, in_ready2); end
      tick();
      tick();
      total++; if (out_data2 !== 8'h33 || out_last2 !== 1'b1)
        begin bad++; $display("FAIL b2b_f%0d_b2 got d=%h l=%b want d=33 l=1", f, out_data2, out_last2); end
      tick();
      exp_fc  = exp_fc + 16'd1;
      exp_fc2 = exp_fc2 + 2'd1;
      total++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0)
        begin bad++; $display("FAIL b2b_f%0d_bubble got r=%b v=%b want r=1 v=0", f, in_ready2, out_valid2); end
      total++; if (frame_count2 !== exp_fc2)
        begin bad++; $display("FAIL b2b_f%0d_fc2 got=%0d want=%0d", f, frame_count2, exp_fc2); end
      total++; if (frame_count !== exp_fc)
        begin bad++; $display("FAIL b2b_f%0d_fc got=%0d want=%0d", f, frame_count, exp_fc); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_frame();
    test_ignore_inputs();
    test_suppress();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
